// File: rtl/soc_timer.sv
// 64-bit free-running timer with prescaler, compare interrupt and a 32-bit register port.
// Reads and writes take effect on the strobe edge; ack and read data follow one cycle later; never busy.
module soc_timer #(
    parameter int p_prescale_width = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_be,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic        i_rd_en,
    output logic [31:0] o_rd_data,
    output logic        o_busy,
    output logic        o_ack,
    output logic        o_irq
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_PRE     = 3'd1;
    localparam logic [2:0] A_CNT_LO  = 3'd2;
    localparam logic [2:0] A_CNT_HI  = 3'd3;
    localparam logic [2:0] A_CMP_LO  = 3'd4;
    localparam logic [2:0] A_CMP_HI  = 3'd5;
    localparam logic [2:0] A_STATUS  = 3'd6;

    logic                        ctrl_en;
    logic                        ctrl_irq_en;
    logic [p_prescale_width-1:0] prescale;
    logic [p_prescale_width-1:0] prescale_wr;
    logic [p_prescale_width-1:0] pre_cnt;
    logic [63:0]                 count;
    logic [63:0]                 cmp;
    logic [31:0]                 shadow_hi;
    logic                        irq_pending;
    logic [31:0]                 rd_mux;
    logic [2:0]                  reg_idx;
    logic                        tick;
    logic                        irq_set;
    logic                        irq_clr;

    logic wr_ctrl, wr_pre, wr_cnt_lo, wr_cnt_hi, wr_cmp_lo, wr_cmp_hi, wr_status;
    logic rd_cnt_lo;

    // Only the word index is decoded; the remaining offset bits are ignored.
    logic unused_addr;
    assign unused_addr = &{1'b0, i_addr[31:5], i_addr[1:0]};

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign reg_idx   = i_addr[4:2];
    assign wr_ctrl   = i_wr_en && (reg_idx == A_CTRL);
    assign wr_pre    = i_wr_en && (reg_idx == A_PRE);
    assign wr_cnt_lo = i_wr_en && (reg_idx == A_CNT_LO);
    assign wr_cnt_hi = i_wr_en && (reg_idx == A_CNT_HI);
    assign wr_cmp_lo = i_wr_en && (reg_idx == A_CMP_LO);
    assign wr_cmp_hi = i_wr_en && (reg_idx == A_CMP_HI);
    assign wr_status = i_wr_en && (reg_idx == A_STATUS);
    assign rd_cnt_lo = i_rd_en && (reg_idx == A_CNT_LO);

    // PRESCALE may be narrower than a word, so lanes are merged bit by bit.
    always_comb begin
        prescale_wr = prescale;
        for (int i = 0; i < p_prescale_width; i++) begin
            if (i_be[i/8]) begin
                prescale_wr[i] = i_wr_data[i];
            end
        end
    end

    assign tick    = ctrl_en && (pre_cnt == prescale);
    assign irq_set = ctrl_en && (count >= cmp);
    assign irq_clr = wr_status && i_be[0] && i_wr_data[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_ctrl && i_be[0]) begin
            ctrl_en     <= i_wr_data[0];
            ctrl_irq_en <= i_wr_data[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescale <= '0;
        end else if (wr_pre) begin
            prescale <= prescale_wr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (wr_pre || !ctrl_en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // A software write to either half suppresses that edge's increment entirely.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (wr_cnt_lo) begin
            count[31:0] <= merge_be(count[31:0], i_wr_data, i_be);
        end else if (wr_cnt_hi) begin
            count[63:32] <= merge_be(count[63:32], i_wr_data, i_be);
        end else if (tick) begin
            count <= count + 64'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmp <= '1;
        end else if (wr_cmp_lo) begin
            cmp[31:0] <= merge_be(cmp[31:0], i_wr_data, i_be);
        end else if (wr_cmp_hi) begin
            cmp[63:32] <= merge_be(cmp[63:32], i_wr_data, i_be);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_pending <= 1'b0;
        end else if (irq_set) begin
            irq_pending <= 1'b1;
        end else if (irq_clr) begin
            irq_pending <= 1'b0;
        end
    end

    // Upper word is captured with the low read so LO-then-HI is coherent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_hi <= '0;
        end else if (rd_cnt_lo) begin
            shadow_hi <= count[63:32];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            A_CTRL:   rd_mux = {30'd0, ctrl_irq_en, ctrl_en};
            A_PRE:    rd_mux = 32'(prescale);
            A_CNT_LO: rd_mux = count[31:0];
            A_CNT_HI: rd_mux = shadow_hi;
            A_CMP_LO: rd_mux = cmp[31:0];
            A_CMP_HI: rd_mux = cmp[63:32];
            A_STATUS: rd_mux = {31'd0, irq_pending};
            default:  rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
            o_ack     <= 1'b0;
        end else begin
            o_ack <= i_wr_en || i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= rd_mux;
            end
        end
    end

    assign o_busy = 1'b0;
    assign o_irq  = irq_pending && ctrl_irq_en;

endmodule

// File: tb/tb_soc_timer.sv
// Directed bench for soc_timer: register access, prescaled counting, compare irq, shadow reads, reset.
module tb_soc_timer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [31:0] i_addr = '0;
    logic [3:0]  i_be = '0;
    logic        i_wr_en = 1'b0;
    logic [31:0] i_wr_data = '0;
    logic        i_rd_en = 1'b0;
    logic [31:0] o_rd_data;
    logic        o_busy;
    logic        o_ack;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PRE    = 32'h04;
    localparam logic [31:0] A_CLO    = 32'h08;
    localparam logic [31:0] A_CHI    = 32'h0C;
    localparam logic [31:0] A_CMPLO  = 32'h10;
    localparam logic [31:0] A_CMPHI  = 32'h14;
    localparam logic [31:0] A_STAT   = 32'h18;
    localparam logic [31:0] A_UNM    = 32'h1C;

    soc_timer #(.p_prescale_width(16)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_addr    (i_addr),
        .i_be      (i_be),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (i_rd_en),
        .o_rd_data (o_rd_data),
        .o_busy    (o_busy),
        .o_ack     (o_ack),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the access is sampled on the following posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        i_addr = a; i_wr_data = d; i_be = be; i_wr_en = 1'b1;
        @(negedge i_clk);
        i_wr_en = 1'b0; i_be = '0;
        chk("wr_ack", {31'd0, o_ack}, 32'd1);
        chk("wr_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        i_addr = a; i_rd_en = 1'b1;
        @(negedge i_clk);
        i_rd_en = 1'b0;
        chk("rd_ack", {31'd0, o_ack}, 32'd1);
        chk(tag, o_rd_data, exp);
    endtask

    task automatic check_reset_regs();
        rd(A_CTRL,  32'h0000_0000, "rst_ctrl");
        rd(A_PRE,   32'h0000_0000, "rst_pre");
        rd(A_CLO,   32'h0000_0000, "rst_cnt_lo");
        rd(A_CHI,   32'h0000_0000, "rst_cnt_hi");
        rd(A_CMPLO, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(A_CMPHI, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(A_STAT,  32'h0000_0000, "rst_status");
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_rd_data", o_rd_data, 32'd0);
        chk("rst_ack", {31'd0, o_ack}, 32'd0);
        chk("rst_irq", {31'd0, o_irq}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("por_rd_data", o_rd_data, 32'd0);
        chk("por_ack", {31'd0, o_ack}, 32'd0);
        chk("por_irq", {31'd0, o_irq}, 32'd0);
        chk("por_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_reset_regs();

        // Unused bits, unmapped offset, single-cycle ack, byte-lane write
        wr(A_CTRL, 32'hFFFF_FFFC, 4'hF);
        rd(A_CTRL, 32'h0000_0000, "ctrl_unused_bits");
        wr(A_PRE, 32'hFFFF_FFFF, 4'hF);
        rd(A_PRE, 32'h0000_FFFF, "pre_width");
        wr(A_PRE, 32'h0000_0000, 4'hF);
        wr(A_UNM, 32'hFFFF_FFFF, 4'hF);
        rd(A_UNM, 32'h0000_0000, "unmapped_rd");
        chk("ack_one_cycle", {31'd0, o_ack}, 32'd1);
        @(negedge i_clk);
        chk("ack_drops", {31'd0, o_ack}, 32'd0);
        rd(A_CTRL, 32'h0000_0000, "unmapped_wr_no_effect");
        wr(A_CMPLO, 32'h0000_AB00, 4'b0010);
        rd(A_CMPLO, 32'hFFFF_ABFF, "cmp_lo_byte_lane");
        rd(A_CMPHI, 32'hFFFF_FFFF, "cmp_hi_untouched");

        // Prescale 3: one increment every 4 cycles
        do_reset();
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        rd(A_CLO, 32'd0, "presc_cnt0");
        repeat (3) @(negedge i_clk);
        rd(A_CLO, 32'd1, "presc_cnt1");
        repeat (3) @(negedge i_clk);
        rd(A_CLO, 32'd2, "presc_cnt2");

        // Compare interrupt, W1C while set condition holds, then clear
        do_reset();
        wr(A_CMPLO, 32'd10, 4'hF);
        wr(A_CMPHI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        chk("irq_start_low", {31'd0, o_irq}, 32'd0);
        repeat (10) @(negedge i_clk);
        chk("irq_before_cmp", {31'd0, o_irq}, 32'd0);
        @(negedge i_clk);
        chk("irq_rises", {31'd0, o_irq}, 32'd1);
        wr(A_STAT, 32'd1, 4'h1);
        chk("irq_set_wins", {31'd0, o_irq}, 32'd1);
        rd(A_STAT, 32'd1, "status_pending");
        wr(A_CMPLO, 32'hFFFF_FFFF, 4'hF);
        wr(A_STAT, 32'd1, 4'h1);
        chk("irq_cleared", {31'd0, o_irq}, 32'd0);
        rd(A_STAT, 32'd0, "status_cleared");
        wr(A_CTRL, 32'd0, 4'hF);

        // Carry into the high word and shadow coherence
        do_reset();
        wr(A_CHI, 32'd0, 4'hF);
        wr(A_CLO, 32'hFFFF_FFFE, 4'hF);
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        rd(A_CLO, 32'hFFFF_FFFE, "carry_lo_a");
        rd(A_CHI, 32'h0000_0000, "carry_hi_shadow_a");
        rd(A_CLO, 32'h0000_0000, "carry_lo_b");
        rd(A_CHI, 32'h0000_0001, "carry_hi_shadow_b");

        // 64-bit wrap with irq disabled
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF);
        wr(A_CHI, 32'hFFFF_FFFF, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        @(negedge i_clk);
        rd(A_CLO, 32'd0, "wrap_lo");
        rd(A_CHI, 32'd0, "wrap_hi");
        chk("wrap_no_irq", {31'd0, o_irq}, 32'd0);

        // Write priority over increment
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF);
        wr(A_CHI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        wr(A_CHI, 32'd5, 4'hF);
        rd(A_CLO, 32'hFFFF_FFFF, "hi_wr_no_carry_lo");
        rd(A_CHI, 32'd5, "hi_wr_value");
        wr(A_CLO, 32'h55, 4'hF);
        rd(A_CLO, 32'h55, "lo_wr_beats_inc");
        wr(A_CTRL, 32'd0, 4'hF);

        // Asynchronous reset mid-count with irq asserted and an ack in flight
        wr(A_CMPLO, 32'd0, 4'hF);
        wr(A_CMPHI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        @(negedge i_clk);
        chk("pre_rst_irq", {31'd0, o_irq}, 32'd1);
        rd(A_CTRL, 32'd3, "pre_rst_ctrl");
        i_addr = A_CHI; i_rd_en = 1'b1;
        @(posedge i_clk);
        #1;
        i_rd_en = 1'b0;
        chk("pre_rst_ack", {31'd0, o_ack}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_ack", {31'd0, o_ack}, 32'd0);
        chk("async_rst_irq", {31'd0, o_irq}, 32'd0);
        chk("async_rst_rd_data", o_rd_data, 32'd0);
        chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_no_ack", {31'd0, o_ack}, 32'd0);
        chk("post_rst_irq", {31'd0, o_irq}, 32'd0);
        check_reset_regs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_timer.md
SOC_TIMER -- requirements
Module: soc_timer

Interface
REQ-001 SHALL have parameter p_prescale_width, default 16: width of the PRESCALE register and the internal prescale counter (1..32).
REQ-002 SHALL have port i_clk, input, 1: global clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_addr, input, 32: offset within the peripheral window (base already stripped); only bits [4:2] decoded.
REQ-005 SHALL have port i_be, input, 4: write byte enables, bit n gates wr_data[8n+7:8n].
REQ-006 SHALL have port i_wr_en, input, 1: write strobe, one cycle per access.
REQ-007 SHALL have port i_wr_data, input, 32: write data.
REQ-008 SHALL have port i_rd_en, input, 1: read strobe, one cycle per access.
REQ-009 SHALL have port o_rd_data, output, 32: registered read data.
REQ-010 SHALL have port o_busy, output, 1: peripheral busy; constant 0 in this block.
REQ-011 SHALL have port o_ack, output, 1: transfer acknowledge.
REQ-012 SHALL have port o_irq, output, 1: level interrupt = irq_pending AND CTRL.irq_en.

Function
REQ-013 SHALL map registers by i_addr[4:2]: 0 CTRL (bit0 en, bit1 irq_en), 1 PRESCALE, 2 COUNT_LO, 3 COUNT_HI, 4 CMP_LO, 5 CMP_HI, 6 STATUS (bit0 irq_pending, W1C), 7 unmapped.
REQ-014 SHALL apply a write on the edge where i_wr_en=1, per byte lane per i_be; unwritten bytes and bits beyond a register's width unchanged.
REQ-015 SHALL, on the edge where i_rd_en=1, register o_rd_data from the addressed register, so data is valid the cycle after the strobe and held until the next read.
REQ-016 SHALL assert o_ack for exactly one cycle, the cycle after any edge sampling i_wr_en=1 or i_rd_en=1, including unmapped addresses.
REQ-017 SHALL return 0 on reads of the unmapped offset and on unused bits of CTRL, PRESCALE and STATUS; writes to the unmapped offset SHALL have no effect.
REQ-018 SHALL, when CTRL.en=1, advance a prescale counter every cycle; when it equals PRESCALE it SHALL return to 0 and the 64-bit COUNT SHALL increment by 1 on that edge.
REQ-019 SHALL, with PRESCALE=0, increment COUNT every cycle while enabled.
REQ-020 SHALL clear the prescale counter to 0 while CTRL.en=0 and on any write to PRESCALE.
REQ-021 SHALL wrap COUNT from 0xFFFF_FFFF_FFFF_FFFF to 0 without flag or interrupt.
REQ-022 SHALL give a write to COUNT_LO/HI priority over an increment on the same edge; only the written word changes, the other word is neither incremented nor carried that edge.
REQ-023 SHALL, on a COUNT_LO read, latch COUNT[63:32] into a shadow register on the same edge; a COUNT_HI read SHALL return the shadow, giving a coherent 64-bit LO-then-HI read.
REQ-024 SHALL set irq_pending on any edge where CTRL.en=1 and COUNT >= CMP (unsigned 64-bit), evaluated on registered values.
REQ-025 SHALL clear irq_pending on a STATUS write with i_be[0]=1 and wr_data[0]=1; if the set condition holds on the same edge, set SHALL win.
REQ-026 SHALL not accept simultaneous i_wr_en and i_rd_en; the bench never drives both.

Reset
REQ-027 SHALL, while i_rst_n=0, force CTRL=0, PRESCALE=0, COUNT=0, CMP=0xFFFF_FFFF_FFFF_FFFF, shadow=0, prescale counter=0, irq_pending=0, o_rd_data=0, o_ack=0, o_irq=0, o_busy=0.
REQ-028 SHALL abandon any in-flight access when reset asserts mid-transfer; no ack issues after release for an access sampled before reset.

Verification
REQ-029 SHALL cover: write PRESCALE=3, CTRL=1 -> COUNT increments once every 4 cycles; COUNT_LO reads 0,1,2 at 4-cycle spacing.
REQ-030 SHALL cover: write CMP_LO=10, CMP_HI=0, CTRL=3 -> o_irq rises the cycle after COUNT reaches 10; W1C STATUS with COUNT>=CMP keeps o_irq=1; set CMP_LO=0xFFFF_FFFF, then W1C -> o_irq=0.
REQ-031 SHALL cover: COUNT_HI=0, COUNT_LO=0xFFFF_FFFE, PRESCALE=0, enable -> LO read 0x0000_0000 later, HI read 0x0000_0001 (shadow coherent); preload all-ones -> wraps to 0, no irq with CMP all-ones cleared beforehand.
REQ-032 SHALL cover: write COUNT_LO=0x55 on an increment edge -> COUNT_LO reads 0x55, not 0x56; byte write i_be=4'b0010 data 0xAB00 to CMP_LO -> CMP_LO=0xFFFF_ABFF.
REQ-033 SHALL cover: read offset 7 -> o_rd_data=0, o_ack one cycle; every access acks exactly once, o_busy always 0.
REQ-034 SHALL cover: assert i_rst_n=0 mid-count with o_irq=1 -> all outputs 0 immediately (asynchronous), registers at REQ-027 values after release.
